// File: rtl/shift_scheduler_if.sv
// ---------------------------------------------------------------------------
// shift_scheduler_if
//   Bundles the two requester handshakes and the response handshake of the
//   shared shift scheduler.
//
//   Signals:
//     reqN_valid / reqN_ready : request handshake for requester N (0 or 1)
//     reqN_data               : operand
//     reqN_amt                : shift amount 0..31
//     reqN_op                 : 00 SLL, 01 SRL, 10 SRA, 11 treated as SLL
//     resp_valid / resp_ready : result handshake towards the consumer
//     resp_data               : shifted result
//     resp_id                 : requester that produced resp_data
//
//   Modports:
//     master : requesters plus consumer side (drives requests, accepts results)
//     slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface shift_scheduler_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic [4:0]        req0_amt;
  logic [1:0]        req0_op;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic [4:0]        req1_amt;
  logic [1:0]        req1_op;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_id;

  modport master (
    output req0_valid, req0_data, req0_amt, req0_op,
    output req1_valid, req1_data, req1_amt, req1_op,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req0_valid, req0_data, req0_amt, req0_op,
    input  req1_valid, req1_data, req1_amt, req1_op,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/shift_scheduler.sv
// ---------------------------------------------------------------------------
// shift_scheduler
//   Shares one 32-bit left barrel shifter between two requesters (ALU issue
//   logic on port 0, address/immediate formatting on port 1). Supports SLL,
//   SRL and SRA; right shifts are formed by bit-reversing around the left
//   shifter. Round-robin arbitration, valid/ready on both sides and a
//   one-entry registered result buffer with 1-cycle accept-to-result latency.
//
//   Ports:
//     clock      : rising-edge clock
//     reset_n    : asynchronous active-low reset
//     bus        : shift_scheduler_if.slave (both requesters + response)
//   Optional (macro SHIFT_SCHED_STATS_EN defined):
//     stats_clr  : synchronous clear of both grant counters
//     grant_cnt0 : saturating count of grants to requester 0
//     grant_cnt1 : saturating count of grants to requester 1
//
//   Parameters:
//     DATA_W : datapath width, must be 32 to match leftshifter
//     CNT_W  : grant counter width (stats build only)
// ---------------------------------------------------------------------------

// Team left barrel shifter: five log stages of 1/2/4/8/16 positions.
module leftshifter (
  input  logic [31:0] in_data,
  input  logic [4:0]  shamt,
  output logic [31:0] out_data
);
  logic [31:0] stage;

  always_comb begin
    stage = in_data;
    for (int i = 0; i < 5; i++) begin
      if (shamt[i]) begin
        stage = stage << (1 << i);
      end
    end
    out_data = stage;
  end
endmodule

module shift_scheduler #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  shift_scheduler_if.slave   bus
`ifdef SHIFT_SCHED_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [CNT_W-1:0]   grant_cnt0,
  output logic [CNT_W-1:0]   grant_cnt1
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_id_q, resp_id_d;
  logic              rr_q, rr_d;

  logic              winner;
  logic              can_accept;
  logic              fire;
  logic [DATA_W-1:0] sel_data;
  logic [4:0]        sel_amt;
  logic [1:0]        sel_op;
  logic              is_right;
  logic              invert;
  logic [DATA_W-1:0] pre_data;
  logic [DATA_W-1:0] shifter_in;
  logic [DATA_W-1:0] shifter_out;
  logic [DATA_W-1:0] post_data;
  logic [DATA_W-1:0] shift_result;

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // State register: buffer occupancy, buffered result and round-robin pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      resp_data_q <= '0;
      resp_id_q   <= 1'b0;
      rr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
      rr_q        <= rr_d;
    end
  end

  // Arbitration and handshake outputs. Ready is masked by reset_n so no
  // request is accepted while reset is held, even though state reads EMPTY.
  always_comb begin
    winner = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      winner = rr_q;
    end else if (bus.req1_valid) begin
      winner = 1'b1;
    end

    // A draining buffer can take a new result in the same cycle.
    can_accept = (state_q == EMPTY) || (bus.resp_ready && (state_q == FULL));

    bus.req0_ready = reset_n && can_accept && bus.req0_valid && !winner;
    bus.req1_ready = reset_n && can_accept && bus.req1_valid &&  winner;
    fire           = bus.req0_ready || bus.req1_ready;

    bus.resp_valid = (state_q == FULL);
    bus.resp_data  = resp_data_q;
    bus.resp_id    = resp_id_q;
  end

  // Operand select and reversal around the shared left shifter. SRA with a
  // negative operand works on the complement so the vacated bits come back
  // as ones after the final inversion.
  always_comb begin
    sel_data = winner ? bus.req1_data : bus.req0_data;
    sel_amt  = winner ? bus.req1_amt  : bus.req0_amt;
    sel_op   = winner ? bus.req1_op   : bus.req0_op;

    is_right = (sel_op == OP_SRL) || (sel_op == OP_SRA);
    invert   = (sel_op == OP_SRA) && sel_data[DATA_W-1];

    pre_data     = invert ? ~sel_data : sel_data;
    shifter_in   = is_right ? rev32(pre_data) : pre_data;
    post_data    = is_right ? rev32(shifter_out) : shifter_out;
    shift_result = invert ? ~post_data : post_data;
  end

  leftshifter u_leftshifter (
    .in_data  (shifter_in),
    .shamt    (sel_amt),
    .out_data (shifter_out)
  );

  // Next-state: a fire (re)fills the buffer, otherwise a drain empties it.
  always_comb begin
    state_d     = state_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    rr_d        = rr_q;
    if (fire) begin
      state_d     = FULL;
      resp_data_d = shift_result;
      resp_id_d   = winner;
      rr_d        = ~winner;
    end else if ((state_q == FULL) && bus.resp_ready) begin
      state_d = EMPTY;
    end
  end

`ifdef SHIFT_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Grant counters: clear wins over increment, increments saturate.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (stats_clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (bus.req0_ready && (cnt0_q != '1)) begin
        cnt0_d = cnt0_q + 1'b1;
      end
      if (bus.req1_ready && (cnt1_q != '1)) begin
        cnt1_d = cnt1_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_shift_scheduler.sv
// ---------------------------------------------------------------------------
// tb_shift_scheduler
//   Directed bench for shift_scheduler: a vector table of single-requester
//   shifts plus hand-written sequences for contention, stall, reset while
//   full and (with SHIFT_SCHED_STATS_EN) saturating grant counters.
// ---------------------------------------------------------------------------
module tb_shift_scheduler;

  logic clock;
  logic reset_n;
  int   compareCount;
  int   mismatchCount;

  shift_scheduler_if #(.DATA_W(32)) ifc ();

`ifdef SHIFT_SCHED_STATS_EN
  logic       stats_clr;
  logic [1:0] grant_cnt0;
  logic [1:0] grant_cnt1;

  shift_scheduler #(.DATA_W(32), .CNT_W(2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (ifc.slave),
    .stats_clr  (stats_clr),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );
`else
  shift_scheduler #(.DATA_W(32), .CNT_W(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        req;
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  amt;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[12];

  // Drive one requester's request fields.
  task automatic applyStimulus(input logic idx, input logic valid, input logic [1:0] op,
                               input logic [31:0] data, input logic [4:0] amt);
    if (idx == 1'b0) begin
      ifc.req0_valid = valid;
      ifc.req0_op    = op;
      ifc.req0_data  = data;
      ifc.req0_amt   = amt;
    end else begin
      ifc.req1_valid = valid;
      ifc.req1_op    = op;
      ifc.req1_data  = data;
      ifc.req1_amt   = amt;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;

    vecs[0]  = '{1'b0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[1]  = '{1'b1, 2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000};
    vecs[2]  = '{1'b1, 2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000};
    vecs[3]  = '{1'b1, 2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
    vecs[4]  = '{1'b0, 2'b00, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[5]  = '{1'b1, 2'b10, 32'h8000_0001, 5'd0,  32'h8000_0001};
    vecs[6]  = '{1'b0, 2'b11, 32'hDEAD_BEEF, 5'd4,  32'hEADB_EEF0};
    vecs[7]  = '{1'b1, 2'b10, 32'hF000_0000, 5'd31, 32'hFFFF_FFFF};
    vecs[8]  = '{1'b0, 2'b01, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001};
    vecs[9]  = '{1'b1, 2'b00, 32'hA5A5_A5A5, 5'd8,  32'hA5A5_A500};
    vecs[10] = '{1'b0, 2'b10, 32'h8000_0000, 5'd1,  32'hC000_0000};
    vecs[11] = '{1'b1, 2'b01, 32'h1234_5678, 5'd12, 32'h0001_2345};

`ifdef SHIFT_SCHED_STATS_EN
    stats_clr = 1'b0;
`endif
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 5'd0);
    applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 5'd0);
    ifc.resp_ready = 1'b0;

    // Reset values, with a request pending to show ready is held low.
    reset_n = 1'b0;
    ifc.req0_valid = 1'b1;
    #12;
    checkOutput("reset req0_ready", {31'b0, ifc.req0_ready}, 32'd0);
    checkOutput("reset resp_valid", {31'b0, ifc.resp_valid}, 32'd0);
    checkOutput("reset resp_data", ifc.resp_data, 32'h0);
    checkOutput("reset resp_id", {31'b0, ifc.resp_id}, 32'd0);
    ifc.req0_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    // Table: one requester at a time, consumer always ready.
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      applyStimulus(vecs[i].req, 1'b1, vecs[i].op, vecs[i].data, vecs[i].amt);
      applyStimulus(~vecs[i].req, 1'b0, 2'b00, 32'h0, 5'd0);
      ifc.resp_ready = 1'b1;
      #1;
      checkOutput($sformatf("vec%0d ready", i),
                  {31'b0, vecs[i].req ? ifc.req1_ready : ifc.req0_ready}, 32'd1);
      @(posedge clock);
      #1;
      checkOutput($sformatf("vec%0d resp_valid", i), {31'b0, ifc.resp_valid}, 32'd1);
      checkOutput($sformatf("vec%0d resp_data", i), ifc.resp_data, vecs[i].expData);
      checkOutput($sformatf("vec%0d resp_id", i), {31'b0, ifc.resp_id}, {31'b0, vecs[i].req});
    end

    // Contention after a fresh reset: grants alternate 0,1,0,1 with no bubble.
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 5'd0);
    applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 5'd0);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 2'b00, 32'h0000_0001, 5'd1);
    applyStimulus(1'b1, 1'b1, 2'b00, 32'h0000_0001, 5'd2);
    ifc.resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checkOutput($sformatf("rr%0d req0_ready", k), {31'b0, ifc.req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rr%0d req1_ready", k), {31'b0, ifc.req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      @(posedge clock);
      #1;
      checkOutput($sformatf("rr%0d resp_valid", k), {31'b0, ifc.resp_valid}, 32'd1);
      checkOutput($sformatf("rr%0d resp_id", k), {31'b0, ifc.resp_id}, (k % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rr%0d resp_data", k), ifc.resp_data, (k % 2 == 1) ? 32'h4 : 32'h2);
      @(negedge clock);
    end

    // Stall: buffer holds req1's result (4); req0 waits three cycles.
    applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 5'd0);
    applyStimulus(1'b0, 1'b1, 2'b01, 32'h0000_00F0, 5'd4);
    ifc.resp_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      checkOutput($sformatf("stall%0d req0_ready", s), {31'b0, ifc.req0_ready}, 32'd0);
      @(posedge clock);
      #1;
      checkOutput($sformatf("stall%0d resp_valid", s), {31'b0, ifc.resp_valid}, 32'd1);
      checkOutput($sformatf("stall%0d resp_data", s), ifc.resp_data, 32'h4);
      checkOutput($sformatf("stall%0d resp_id", s), {31'b0, ifc.resp_id}, 32'd1);
      @(negedge clock);
    end
    ifc.resp_ready = 1'b1;
    #1;
    checkOutput("unstall req0_ready", {31'b0, ifc.req0_ready}, 32'd1);
    @(posedge clock);
    #1;
    checkOutput("unstall resp_data", ifc.resp_data, 32'h0000_000F);
    checkOutput("unstall resp_id", {31'b0, ifc.resp_id}, 32'd0);
    checkOutput("unstall resp_valid", {31'b0, ifc.resp_valid}, 32'd1);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 5'd0);
    @(posedge clock);
    #1;
    checkOutput("drain resp_valid", {31'b0, ifc.resp_valid}, 32'd0);
    checkOutput("drain resp_data held", ifc.resp_data, 32'h0000_000F);

    // Reset while FULL: pointer is 1 going in, must return to 0.
    @(negedge clock);
    applyStimulus(1'b0, 1'b1, 2'b00, 32'h0000_0003, 5'd0);
    ifc.resp_ready = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("prereset resp_valid", {31'b0, ifc.resp_valid}, 32'd1);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 5'd0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset resp_valid", {31'b0, ifc.resp_valid}, 32'd0);
    checkOutput("async reset resp_data", ifc.resp_data, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("post reset resp_valid", {31'b0, ifc.resp_valid}, 32'd0);
    @(negedge clock);
    applyStimulus(1'b0, 1'b1, 2'b00, 32'h0000_0005, 5'd0);
    applyStimulus(1'b1, 1'b1, 2'b00, 32'h0000_0006, 5'd0);
    #1;
    checkOutput("post reset req0_ready", {31'b0, ifc.req0_ready}, 32'd1);
    checkOutput("post reset req1_ready", {31'b0, ifc.req1_ready}, 32'd0);
    @(posedge clock);
    #1;
    checkOutput("post reset resp_id", {31'b0, ifc.resp_id}, 32'd0);
    checkOutput("post reset resp_data", ifc.resp_data, 32'h5);

`ifdef SHIFT_SCHED_STATS_EN
    // Five req0 grants into a 2-bit counter saturate at 3.
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 5'd0);
    applyStimulus(1'b1, 1'b0, 2'b00, 32'h0, 5'd0);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    ifc.resp_ready = 1'b1;
    applyStimulus(1'b0, 1'b1, 2'b00, 32'h1, 5'd0);
    repeat (5) @(negedge clock);
    applyStimulus(1'b0, 1'b0, 2'b00, 32'h0, 5'd0);
    #1;
    checkOutput("grant_cnt0 saturated", {30'b0, grant_cnt0}, 32'd3);
    checkOutput("grant_cnt1 idle", {30'b0, grant_cnt1}, 32'd0);
    stats_clr = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("grant_cnt0 cleared", {30'b0, grant_cnt0}, 32'd0);
    @(negedge clock);
    stats_clr = 1'b0;
`endif

    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/shift_scheduler.md
Name: shift_scheduler

Overview:
- Shares one 32-bit left barrel shifter (the team's `leftshifter`, instantiated once) between two requesters.
- Supports logical left, logical right and arithmetic right. Right shifts are built by bit-reversing around the shared left shifter.
- Round-robin arbitration, valid/ready handshakes on both sides, one-entry registered result buffer.
- Sits between the ALU issue logic (requester 0) and the address/immediate formatting path (requester 1).

Parameters:
- DATA_W, 32, datapath width; must be 32 to match the shared shifter.
- CNT_W, 16, width of grant counters (used only with the optional feature).

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a shift request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_data  in  32  operand.
- req0_amt  in  5  shift amount 0..31.
- req0_op  in  2  00 = SLL, 01 = SRL, 10 = SRA, 11 = reserved (treated as SLL).
- req1_valid, req1_ready, req1_data, req1_amt, req1_op  same as requester 0, for requester 1.
- resp_valid  out  1  result buffer holds a result.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  32  shifted result.
- resp_id  out  1  index of the requester that produced the result.

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - resp_valid = 0, resp_data = 0, resp_id = 0.
  - Round-robin pointer rr = 0 (requester 0 has priority first).
  - req0_ready = req1_ready = 0 while in reset.
- States: EMPTY (buffer empty) and FULL (buffer holds an unconsumed result).
- can_accept = (state == EMPTY) | (resp_valid & resp_ready). Pass-through acceptance on a drain cycle is allowed.
- Arbitration (combinational, when can_accept = 1):
  - Only one valid: that requester wins.
  - Both valid: the requester indicated by rr wins.
  - reqN_ready = 1 only for the winner. Loser's ready = 0. Both ready = 0 when can_accept = 0.
- Shift path (combinational on the winner's operands):
  - SLL: out = leftshift(data, amt).
  - SRL: out = rev(leftshift(rev(data), amt)), where rev is a 32-bit bit reversal.
  - SRA with data[31] = 0: same as SRL.
  - SRA with data[31] = 1: out = ~rev(leftshift(rev(~data), amt)). Sign bits fill.
  - amt = 0 returns data unchanged for every op.
- Handshake fire (valid & ready for the winner):
  - Next edge: resp_data <= shift result, resp_id <= winner, resp_valid <= 1, state <= FULL, rr <= ~winner.
  - Latency: exactly 1 cycle from accept to resp_valid.
- Drain with no new fire: resp_valid & resp_ready & no fire leads to resp_valid <= 0 and state EMPTY. resp_data and resp_id hold their last values.
- Simultaneous drain and fire: the buffer is overwritten with the new result, resp_valid stays 1, no bubble. Sustained throughput is 1 result per cycle.
- rr updates only on a fire. Idle cycles and stalls leave rr unchanged.
- Stall (FULL and resp_ready = 0):
  - resp_data, resp_id and resp_valid are held stable.
  - Requesters must hold valid and operands; they may not drop or change a request until accepted.
- Reset asserted mid-operation: the buffered result is discarded, pointer returns to 0, and no response is emitted after release.

Optional Feature:
- Macro SHIFT_SCHED_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1, each CNT_W bits.
  - Each counter increments on every fire for its requester and saturates at all-ones (no wrap).
  - Both counters clear on reset_n = 0 and on a new input stats_clr (1 bit, synchronous, highest priority over increment).
- Undefined: no counters, no stats_clr or grant_cnt ports. Behaviour is otherwise identical.

Test Plan:
- req0 only: SLL, data 0x0000_0001, amt 31 -> one cycle later resp_valid = 1, resp_data 0x8000_0000, resp_id 0.
- req1: SRA, data 0x8000_0000, amt 4 -> 0xF800_0000. Then SRL with the same operands -> 0x0800_0000. Then SRA, data 0x7FFF_FFFF, amt 31 -> 0x0000_0000.
- Both valid continuously, resp_ready = 1 -> grants alternate 0,1,0,1 starting with 0 after reset. One result per cycle with no bubbles.
- resp_ready = 0 for 3 cycles while FULL -> req ready = 0 and resp_data held. On the cycle resp_ready rises, the pending request is accepted in that same cycle.
- reset_n pulsed low while FULL -> resp_valid = 0 immediately (async). After release, first contention is granted to requester 0.
- With SHIFT_SCHED_STATS_EN and CNT_W = 2: 5 fires from req0 -> grant_cnt0 = 3 (saturated). Pulse stats_clr -> 0.
